// File: rtl/orao_pkg.sv
// Shared types for the Orao boot-key sequencer: key actions, sequencer states
// and the 16-slot boot script.
package orao_pkg;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_RESET,
        ACT_B,
        ACT_C,
        ACT_ENTER
    } act_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Reset, B, C, then Enter three times to reach the BASIC prompt.
    localparam act_t BOOT_SEQ [16] = '{
        ACT_RESET, ACT_NONE, ACT_B,     ACT_NONE,
        ACT_C,     ACT_NONE, ACT_ENTER, ACT_NONE,
        ACT_ENTER, ACT_NONE, ACT_NONE,  ACT_NONE,
        ACT_ENTER, ACT_NONE, ACT_NONE,  ACT_NONE
    };

endpackage

// File: rtl/orao_debounce.sv
// Two-flop synchroniser plus stability counter for one raw board button.
// The rise/fall pulses coincide with the edge on which o_level changes.
module orao_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_db;
    logic          w_done;

    assign w_done = (r_sync[1] != r_db) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            if ((r_sync[1] == r_db) || w_done)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            if (w_done)
                r_db <= r_sync[1];
        end
    end

    assign o_level = r_db;
    assign o_rise  = w_done &  r_sync[1];
    assign o_fall  = w_done & ~r_sync[1];

endmodule

// File: rtl/orao_key_sequencer.sv
// Button conditioning and slot-timed boot keystrokes for the Orao core.
// Define ORAO_AUTOBOOT_EN to build the boot sequencer; otherwise outputs are the debounced buttons.
module orao_key_sequencer
    import orao_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SLOT_CYCLES     = 8388608
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_reset,
    input  logic btn_b,
    input  logic btn_c,
    input  logic btn_enter,
    output logic n_reset,
    output logic key_b,
    output logic key_c,
    output logic key_enter,
    output logic busy
);

    logic [3:0] w_raw;
    logic [3:0] w_db;
    logic [3:0] w_rise;
    logic [3:0] w_fall;

    assign w_raw = {btn_enter, btn_c, btn_b, btn_reset};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        orao_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .i_clk   (clk),
            .i_rst   (reset),
            .i_btn   (w_raw[g]),
            .o_level (w_db[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );
    end

`ifdef ORAO_AUTOBOOT_EN
    localparam int unsigned SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    state_t        r_state;
    logic [SW-1:0] r_slot;
    logic [3:0]    r_step;

    state_t        w_state_nx;
    logic [SW-1:0] w_slot_nx;
    logic [3:0]    w_step_nx;
    act_t          w_act;
    logic          w_unused;

    assign w_unused = ^{w_rise[0], w_fall[3:1]};

    always_comb begin
        w_state_nx = r_state;
        w_slot_nx  = r_slot;
        w_step_nx  = r_step;
        if (w_fall[0]) begin
            w_state_nx = RUN;
            w_slot_nx  = '0;
            w_step_nx  = '0;
        end else if (r_state == RUN) begin
            if (|w_rise[3:1]) begin
                w_state_nx = IDLE;
                w_slot_nx  = '0;
                w_step_nx  = '0;
            end else if (r_slot == SW'(SLOT_CYCLES - 1)) begin
                w_slot_nx = '0;
                if (r_step == 4'd15) begin
                    w_state_nx = IDLE;
                    w_step_nx  = '0;
                end else begin
                    w_step_nx = r_step + 4'd1;
                end
            end else begin
                w_slot_nx = r_slot + SW'(1);
            end
        end
        w_act = (w_state_nx == RUN) ? BOOT_SEQ[w_step_nx] : ACT_NONE;
    end

    // Action terms are decoded from the next state so a key lines up with its slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RUN;
            r_slot    <= '0;
            r_step    <= '0;
            n_reset   <= 1'b0;
            key_b     <= 1'b0;
            key_c     <= 1'b0;
            key_enter <= 1'b0;
            busy      <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_slot    <= w_slot_nx;
            r_step    <= w_step_nx;
            n_reset   <= ~(w_db[0] | (w_act == ACT_RESET));
            key_b     <= w_db[1] | (w_act == ACT_B);
            key_c     <= w_db[2] | (w_act == ACT_C);
            key_enter <= w_db[3] | (w_act == ACT_ENTER);
            busy      <= (w_state_nx == RUN);
        end
    end
`else
    logic w_unused;

    assign w_unused = ^{w_rise, w_fall, 32'(SLOT_CYCLES)};
    assign busy     = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_reset   <= 1'b0;
            key_b     <= 1'b0;
            key_c     <= 1'b0;
            key_enter <= 1'b0;
        end else begin
            n_reset   <= ~w_db[0];
            key_b     <= w_db[1];
            key_c     <= w_db[2];
            key_enter <= w_db[3];
        end
    end
`endif

endmodule

// File: tb/tb_orao_key_sequencer.sv
// Bench for orao_key_sequencer: directed and random button activity checked
// every cycle against a window-based debounce model and a cycle-count boot script.
module tb_orao_key_sequencer;

    localparam int unsigned DEB  = 4;
    localparam int unsigned SLOT = 8;
`ifdef ORAO_AUTOBOOT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_reset = 1'b0;
    logic btn_b = 1'b0;
    logic btn_c = 1'b0;
    logic btn_enter = 1'b0;
    logic n_reset, key_b, key_c, key_enter, busy;

    always #5 clk = ~clk;

    orao_key_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .SLOT_CYCLES    (SLOT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_reset (btn_reset),
        .btn_b     (btn_b),
        .btn_c     (btn_c),
        .btn_enter (btn_enter),
        .n_reset   (n_reset),
        .key_b     (key_b),
        .key_c     (key_c),
        .key_enter (key_enter),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    // Model: raw history per button, debounced level now and one edge ago,
    // and the boot script as "running" plus cycles since entry.
    logic [15:0] hist [4];
    logic [3:0]  mdb;
    logic [3:0]  pdb;
    bit          run;
    int          rc;

    // 0 none, 1 reset, 2 B, 3 C, 4 Enter
    function automatic int act_of(input int step);
        case (step)
            0:         return 1;
            2:         return 2;
            4:         return 3;
            6, 8, 12:  return 4;
            default:   return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        int a;
        a = run ? act_of(rc / int'(SLOT)) : 0;
        chk({tag, ":n_reset"},   n_reset,   ~(pdb[0] | (a == 1)));
        chk({tag, ":key_b"},     key_b,     pdb[1] | (a == 2));
        chk({tag, ":key_c"},     key_c,     pdb[2] | (a == 3));
        chk({tag, ":key_enter"}, key_enter, pdb[3] | (a == 4));
        chk({tag, ":busy"},      busy,      run);
    endtask

    task automatic tick(input string tag);
        logic [3:0] raw;
        logic [3:0] rose;
        logic [3:0] fell;
        bit stable;
        raw = {btn_enter, btn_c, btn_b, btn_reset};
        @(posedge clk);
        #1;
        pdb  = mdb;
        rose = '0;
        fell = '0;
        for (int b = 0; b < 4; b++) begin
            hist[b] = {hist[b][14:0], raw[b]};
            // The level moves once the synchronised input has disagreed for DEB cycles.
            stable = 1'b1;
            for (int unsigned j = 2; j < DEB + 2; j++)
                if (hist[b][j] == mdb[b]) stable = 1'b0;
            if (stable) begin
                mdb[b] = ~mdb[b];
                if (mdb[b]) rose[b] = 1'b1;
                else        fell[b] = 1'b1;
            end
        end
        if (AUTO && fell[0]) begin
            run = 1'b1;
            rc  = 0;
        end else if (run) begin
            if (|rose[3:1]) begin
                run = 1'b0;
            end else begin
                rc++;
                if (rc == 16 * int'(SLOT)) run = 1'b0;
            end
        end
        check_outs(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_reset = v;
            1:       btn_b     = v;
            2:       btn_c     = v;
            default: btn_enter = v;
        endcase
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        btn_reset = 1'b0;
        btn_b     = 1'b0;
        btn_c     = 1'b0;
        btn_enter = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("reset:n_reset",   n_reset,   1'b0);
        chk("reset:key_b",     key_b,     1'b0);
        chk("reset:key_c",     key_c,     1'b0);
        chk("reset:key_enter", key_enter, 1'b0);
        chk("reset:busy",      busy,      AUTO);
        for (int b = 0; b < 4; b++) hist[b] = '0;
        mdb   = '0;
        pdb   = '0;
        run   = AUTO;
        rc    = 0;
        reset = 1'b0;
    endtask

    initial begin
        int off;
        int b;
        logic [3:0] lvl;

        do_reset(3);

        // Boot script (or silence) straight out of reset.
        ticks("boot", 16 * SLOT + 10);

        // Short glitches on each key button never reach an output.
        for (int k = 0; k < 6; k++) begin
            b = 1 + (k % 3);
            set_btn(b, 1'b1);
            ticks("glitch", $urandom_range(1, DEB - 1));
            set_btn(b, 1'b0);
            ticks("glitch_after", 10);
        end

        // Exact-length pulse is accepted; one shorter is rejected.
        btn_enter = 1'b1;
        ticks("len_exact", DEB);
        btn_enter = 1'b0;
        ticks("len_exact_after", 12);

        // Held press: output follows 7 cycles after each raw edge.
        btn_b = 1'b1;
        ticks("press", 20);
        btn_b = 1'b0;
        ticks("release", 12);

        // Restart via btn_reset, then abort with btn_c during the B slot.
        btn_reset = 1'b1;
        ticks("restart_hold", 10);
        btn_reset = 1'b0;
        off = $urandom_range(10, 15);
        for (int i = 0; i < 200; i++) begin
            if (run && rc == off) break;
            tick("restart_run");
        end
        btn_c = 1'b1;
        ticks("abort", 12);
        btn_c = 1'b0;
        ticks("after_abort", 16 * SLOT + 10);

        // Restart and abort debounced on the same edge.
        btn_reset = 1'b1;
        ticks("simul_hold", 10);
        btn_reset = 1'b0;
        btn_b     = 1'b1;
        ticks("simul", 30);
        btn_b = 1'b0;
        ticks("simul_release", 20);
        btn_enter = 1'b1;
        ticks("simul_abort", 12);
        btn_enter = 1'b0;
        ticks("simul_idle", 20);

        // Reset asserted in the middle of a sequence.
        btn_reset = 1'b1;
        ticks("mid_hold", 10);
        btn_reset = 1'b0;
        ticks("mid_run", 30);
        do_reset(2);
        ticks("mid_reboot", 16 * SLOT + 10);

        // Random button traffic.
        lvl = '0;
        for (int k = 0; k < 60; k++) begin
            b = int'($urandom_range(0, 3));
            lvl[b] = ~lvl[b];
            set_btn(b, lvl[b]);
            ticks("random", $urandom_range(1, 2 * DEB + 1));
        end
        btn_reset = 1'b0;
        btn_b     = 1'b0;
        btn_c     = 1'b0;
        btn_enter = 1'b0;
        ticks("random_settle", 16 * SLOT + 20);

        // Quiet period.
        ticks("quiet", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
